// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: arbitrates, registers operands, returns the result.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (port 0 wins) otherwise.
module alu_arbiter #(
  parameter int width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  logic [2:0]       req0_ctrl_i,
  input  logic [2:0]       req1_ctrl_i,
  input  logic [width-1:0] req0_a_i,
  input  logic [width-1:0] req0_b_i,
  input  logic [width-1:0] req1_a_i,
  input  logic [width-1:0] req1_b_i,
  output logic             rsp0_valid_o,
  output logic             rsp1_valid_o,
  input  logic             rsp0_ready_i,
  input  logic             rsp1_ready_i,
  output logic [width-1:0] rsp_out_o,
  output logic             rsp_zero_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [width-1:0] alu_a_o,
  output logic [width-1:0] alu_b_o,
  input  logic [width-1:0] alu_out_i,
  input  logic             alu_zero_i,
  output logic             busy_o
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic [width-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             grant0_s, grant1_s;
  logic             accept_s;
  logic             rsp_hs_s;

`ifdef ALU_ARB_RR_EN
  // last_grant_q holds the port index of the most recent acceptance
  logic last_grant_q, last_grant_d;

  // Round-robin grant: on contention favour the port not served last
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant0_s = last_grant_q;
      grant1_s = ~last_grant_q;
    end else begin
      grant0_s = req0_valid_i;
      grant1_s = req1_valid_i;
    end
  end

  // Track the last granted port
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_s) begin
      last_grant_d = req1_ready_o;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed-priority grant: port 0 wins on contention
  always_comb begin
    grant0_s = req0_valid_i;
    grant1_s = req1_valid_i & ~req0_valid_i;
  end
`endif

  assign req0_ready_o = (state_q == ST_IDLE) && grant0_s;
  assign req1_ready_o = (state_q == ST_IDLE) && grant1_s;
  assign accept_s     = req0_ready_o | req1_ready_o;
  assign rsp_hs_s     = (state_q == ST_RESP) && (owner_q ? rsp1_ready_i : rsp0_ready_i);

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          owner_d = req1_ready_o;
          if (req1_ready_o) begin
            ctrl_d = req1_ctrl_i;
            a_d    = req1_a_i;
            b_d    = req1_b_i;
          end else begin
            ctrl_d = req0_ctrl_i;
            a_d    = req0_a_i;
            b_d    = req0_b_i;
          end
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_out_d    = alu_out_i;
        rsp_zero_d   = alu_zero_i;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Non-owner rsp ready is already excluded by rsp_hs_s
        if (rsp_hs_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      ctrl_q       <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign alu_ctrl_o   = ctrl_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign rsp_out_o    = rsp_out_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
// Grant-order expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [2:0]  req0_ctrl_i = 3'b000, req1_ctrl_i = 3'b000;
  logic [31:0] req0_a_i = 32'd0, req0_b_i = 32'd0, req1_a_i = 32'd0, req1_b_i = 32'd0;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic        rsp0_ready_i = 1'b0, rsp1_ready_i = 1'b0;
  logic [31:0] rsp_out_o;
  logic        rsp_zero_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [31:0] alu_out_i;
  logic        alu_zero_i;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.width(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .req0_ctrl_i(req0_ctrl_i), .req1_ctrl_i(req1_ctrl_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp0_ready_i(rsp0_ready_i), .rsp1_ready_i(rsp1_ready_i),
    .rsp_out_o(rsp_out_o), .rsp_zero_o(rsp_zero_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_out_i(alu_out_i), .alu_zero_i(alu_zero_i),
    .busy_o(busy_o)
  );

  // Shared ALU model
  always_comb begin
    case (alu_ctrl_o)
      3'b000:  alu_out_i = alu_a_o + alu_b_o;
      3'b001:  alu_out_i = alu_a_o - alu_b_o;
      3'b010:  alu_out_i = alu_a_o & alu_b_o;
      3'b011:  alu_out_i = alu_a_o | alu_b_o;
      3'b101:  alu_out_i = (alu_a_o < alu_b_o) ? 32'd1 : 32'd0;
      default: alu_out_i = 32'd0;
    endcase
    alu_zero_i = (alu_out_i == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic do_op(input bit port, input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_out, input logic exp_zero);
    if (port) begin
      req1_valid_i = 1'b1; req1_ctrl_i = ctrl; req1_a_i = a; req1_b_i = b;
    end else begin
      req0_valid_i = 1'b1; req0_ctrl_i = ctrl; req0_a_i = a; req0_b_i = b;
    end
    #1;
    check("req_ready_own", port ? req1_ready_o : req0_ready_o, 32'd1);
    check("req_ready_other", port ? req0_ready_o : req1_ready_o, 32'd0);
    tick();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    check("busy_exec", busy_o, 32'd1);
    check("alu_ctrl", alu_ctrl_o, ctrl);
    check("alu_a", alu_a_o, a);
    check("alu_b", alu_b_o, b);
    check("rsp_valid_exec", {rsp1_valid_o, rsp0_valid_o}, 32'd0);
    tick();
    check("rsp_valid", {rsp1_valid_o, rsp0_valid_o}, port ? 32'd2 : 32'd1);
    check("rsp_out", rsp_out_o, exp_out);
    check("rsp_zero", rsp_zero_o, exp_zero);
    if (port) rsp1_ready_i = 1'b1; else rsp0_ready_i = 1'b1;
    tick();
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    check("busy_done", busy_o, 32'd0);
    check("rsp_valid_done", {rsp1_valid_o, rsp0_valid_o}, 32'd0);
    check("alu_a_held", alu_a_o, a);
  endtask

  initial begin
    int grants[$];
    int gcyc[$];
    int exp_g[4];

    // Reset state
    do_reset();
    check("rst_busy", busy_o, 32'd0);
    check("rst_rsp_valid", {rsp1_valid_o, rsp0_valid_o}, 32'd0);
    check("rst_rsp_out", rsp_out_o, 32'd0);
    check("rst_rsp_zero", rsp_zero_o, 32'd0);
    check("rst_alu_a", alu_a_o, 32'd0);
    check("rst_alu_ctrl", alu_ctrl_o, 32'd0);
    check("rst_ready", {req1_ready_o, req0_ready_o}, 32'd0);

    // Single-requester ops over the ALU codes
    do_op(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0);
    do_op(1'b1, 3'b001, 32'd9, 32'd9, 32'd0, 1'b1);
    do_op(1'b1, 3'b101, 32'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(1'b1, 3'b111, 32'd3, 32'd4, 32'd0, 1'b1);
    do_op(1'b0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    do_op(1'b0, 3'b011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
    do_op(1'b0, 3'b101, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1);

    // Contention with rsp ready tied high
    do_reset();
    req0_ctrl_i = 3'b000; req0_a_i = 32'd1; req0_b_i = 32'd1;
    req1_ctrl_i = 3'b011; req1_a_i = 32'd4; req1_b_i = 32'd2;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    #1;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      if (req0_ready_o && req1_ready_o) check("double_ready", 32'd1, 32'd0);
      if (req0_ready_o) begin grants.push_back(0); gcyc.push_back(c); end
      else if (req1_ready_o) begin grants.push_back(1); gcyc.push_back(c); end
      if (rsp0_valid_o) check("arb_rsp0_out", rsp_out_o, 32'd2);
      if (rsp1_valid_o) check("arb_rsp1_out", rsp_out_o, 32'd6);
      tick();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    check("grant_count", grants.size(), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) check($sformatf("grant_%0d", i), grants[i], exp_g[i]);
    for (int i = 1; i < gcyc.size(); i++) check($sformatf("grant_gap_%0d", i), gcyc[i] - gcyc[i-1], 32'd3);
    tick(); tick(); tick();
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    check("arb_drained", busy_o, 32'd0);

    // Stall in RESP: owner not ready, other port noise ignored
    req0_valid_i = 1'b1; req0_ctrl_i = 3'b000; req0_a_i = 32'd20; req0_b_i = 32'd22;
    tick();
    req0_valid_i = 1'b0;
    tick();
    req1_valid_i = 1'b1; req1_ctrl_i = 3'b001; req1_a_i = 32'd1; req1_b_i = 32'd1;
    rsp1_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("hold_rsp0_valid", rsp0_valid_o, 32'd1);
      check("hold_rsp1_valid", rsp1_valid_o, 32'd0);
      check("hold_rsp_out", rsp_out_o, 32'd42);
      check("hold_req_ready", {req1_ready_o, req0_ready_o}, 32'd0);
      check("hold_busy", busy_o, 32'd1);
      check("hold_alu_a", alu_a_o, 32'd20);
      tick();
    end
    rsp0_ready_i = 1'b1;
    #1;
    check("hs_req1_ready", req1_ready_o, 32'd0);
    req1_valid_i = 1'b0;
    rsp1_ready_i = 1'b0;
    tick();
    rsp0_ready_i = 1'b0;
    check("hold_release_busy", busy_o, 32'd0);
    check("hold_release_valid", {rsp1_valid_o, rsp0_valid_o}, 32'd0);

    // Reset during EXEC drops the op
    req1_valid_i = 1'b1; req1_ctrl_i = 3'b000; req1_a_i = 32'd100; req1_b_i = 32'd1;
    tick();
    req1_valid_i = 1'b0;
    check("pre_rst_busy", busy_o, 32'd1);
    reset_i = 1'b1;
    rsp1_ready_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mid_rst_busy", busy_o, 32'd0);
    check("mid_rst_rsp_out", rsp_out_o, 32'd0);
    check("mid_rst_alu_a", alu_a_o, 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("mid_rst_no_rsp", {rsp1_valid_o, rsp0_valid_o}, 32'd0);
      tick();
    end
    rsp1_ready_i = 1'b0;

    // Clean op after the aborted one
    do_op(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter width, default 32, the datapath operand/result width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have req0_valid / req1_valid  input  1 each  requester i has an operation pending.
REQ-005 SHALL have req0_ready / req1_ready  output  1 each  requester i operation accepted this cycle.
REQ-006 SHALL have req0_ctrl / req1_ctrl  input  3 each  ALU_Control code of requester i.
REQ-007 SHALL have req0_a, req0_b / req1_a, req1_b  input  width each  operands src_A, src_B of requester i.
REQ-008 SHALL have rsp0_valid / rsp1_valid  output  1 each  result for requester i is presented.
REQ-009 SHALL have rsp0_ready / rsp1_ready  input  1 each  requester i takes its result.
REQ-010 SHALL have rsp_out  output  width  registered result; rsp_zero  output  1  registered Zero flag.
REQ-011 SHALL have alu_ctrl  output  3, alu_a / alu_b  output  width, driving the shared ALU from registers.
REQ-012 SHALL have alu_out  input  width, alu_zero  input  1, returned from the shared ALU.
REQ-013 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, EXEC, RESP, one-hot or binary, one op in flight at a time.
REQ-015 IDLE: SHALL compute grant from req valids; reqi_ready = (state==IDLE) && grant_i; at most one ready high.
REQ-016 On req handshake SHALL latch ctrl/a/b into operand registers, record owner, go EXEC.
REQ-017 EXEC: SHALL last exactly one cycle; on its closing edge capture alu_out/alu_zero into rsp_out/rsp_zero, go RESP.
REQ-018 RESP: SHALL hold rsp<owner>_valid high, other rsp valid low, rsp_out/rsp_zero stable until rsp<owner>_ready.
REQ-019 On response handshake SHALL return to IDLE; no new request accepted in the same cycle (min 3 cycles per op).
REQ-020 Latency: request accepted at edge E0 SHALL show rsp valid from edge E1+1 cycle, i.e. after edge E1.
REQ-021 rsp ready of the non-owner SHALL be ignored; req valids SHALL be ignored outside IDLE.
REQ-022 ALU codes SHALL pass unmodified: 000 add, 001 sub, 010 and, 011 or, 101 unsigned set-less-than, others yield 0 with zero=1 (ALU-defined).
REQ-023 alu_ctrl/alu_a/alu_b SHALL change only on request acceptance; held otherwise.
REQ-024 Requesters SHALL hold ctrl/a/b stable while valid is high and ready low; block never drops an accepted op.

Reset
REQ-025 reset SHALL force IDLE, all req ready and rsp valid low, busy 0, rsp_out 0, rsp_zero 0, operand regs 0, last_grant 1.
REQ-026 reset mid EXEC or RESP SHALL discard the in-flight op with no response issued; reset dominates any same-cycle handshake.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: SHALL arbitrate round-robin; both valid -> grant port != last_grant; last_grant updates on each acceptance.
REQ-028 ALU_ARB_RR_EN undefined: SHALL use fixed priority, port 0 always wins when both valid; last_grant register omitted.
REQ-029 Single valid SHALL be granted immediately in either configuration.

Verification
REQ-030 req0 ctrl=000 a=5 b=7 -> req0_ready same cycle, rsp0_valid after second edge, rsp_out=12, rsp_zero=0, rsp1_valid=0.
REQ-031 req1 ctrl=001 a=9 b=9 -> rsp1_valid, rsp_out=0, rsp_zero=1; ctrl=101 a=3 b=32'hFFFFFFFF -> rsp_out=1; ctrl=111 -> rsp_out=0, rsp_zero=1.
REQ-032 both valid continuously, rsp ready tied 1 -> grant order 0,1,0,1 with ALU_ARB_RR_EN; 0,0,0,0 without.
REQ-033 rsp0_ready low 5 cycles in RESP -> rsp0_valid and rsp_out held, req ready low, busy 1; ready high -> IDLE next edge.
REQ-034 reset asserted during EXEC -> next cycle IDLE, busy 0, no rsp valid ever issued for that op.
